// File: rtl/lbm_pkg.sv
// Lattice constants and sequencer state encoding shared by the LBM solver,
// the streaming/collider engines and the distribution RAM wrappers.
package lbm_pkg;

   localparam int LBM_GRID_W = 50;
   localparam int LBM_GRID_H = 50;
   localparam int LBM_N      = LBM_GRID_W * LBM_GRID_H;
   localparam int LBM_ADDR_W = 12;
   localparam int LBM_DRAIN  = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STREAM  = 3'd1,
      ST_S_DRAIN = 3'd2,
      ST_COLLIDE = 3'd3,
      ST_C_WAIT  = 3'd4,
      ST_SWAP    = 3'd5,
      ST_DONE    = 3'd6
   } seq_state_t;

endpackage

// File: rtl/lbm_step_sequencer_if.sv
// Host/engine-facing signal bundle of the LBM step sequencer.
interface lbm_step_sequencer_if
   import lbm_pkg::*;
#(
   parameter int ADDR_W = LBM_ADDR_W
);

   logic              en;
   logic              start;
   logic [31:0]       step;
   logic              stream_valid;
   logic              coll_valid;
   logic              coll_ready;
   logic              coll_wb;
   logic [ADDR_W-1:0] node_addr;
   logic [5:0]        node_x;
   logic [5:0]        node_y;
   logic              bank_sel;
   logic [2:0]        phase;
   logic [31:0]       steps_done;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output en, start, step, coll_ready, coll_wb,
      input  stream_valid, coll_valid, node_addr, node_x, node_y,
             bank_sel, phase, steps_done, busy, done, err
   );

   modport slave (
      input  en, start, step, coll_ready, coll_wb,
      output stream_valid, coll_valid, node_addr, node_x, node_y,
             bank_sel, phase, steps_done, busy, done, err
   );

endinterface

// File: rtl/lattice_scan_counter.sv
// Raster scan over the lattice: x wraps at the row end and bumps y, while the
// linear node address is kept as a running count so no multiplier is needed.
module lattice_scan_counter
   import lbm_pkg::*;
#(
   parameter int GRID_W = LBM_GRID_W,
   parameter int GRID_H = LBM_GRID_H,
   parameter int ADDR_W = LBM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              clear,
   output logic [5:0]        x,
   output logic [5:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
   localparam logic [5:0] Y_MAX = 6'(GRID_H - 1);

   assign last = (x == X_MAX) && (y == Y_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (advance) begin
         addr <= addr + 1'b1;
         if (x == X_MAX) begin
            x <= '0;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lbm_step_sequencer.sv
// Timestep phase controller: stream pass, drain, collide pass, write-back wait,
// ping-pong bank swap, repeated for the latched number of steps.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | after reset, waiting for start
// ST_STREAM  | one streaming request per enabled cycle, nodes 0..N-1
// ST_S_DRAIN | let the last stream read/write-back settle
// ST_COLLIDE | collision requests, address advances on valid && ready
// ST_C_WAIT  | wait until all N collider write-backs have arrived
// ST_SWAP    | bank already toggled and step counted; pick next state
// ST_DONE    | run finished, waiting for the next start
module lbm_step_sequencer
   import lbm_pkg::*;
#(
   parameter int GRID_W = LBM_GRID_W,
   parameter int GRID_H = LBM_GRID_H,
   parameter int ADDR_W = LBM_ADDR_W,
   parameter int DRAIN  = LBM_DRAIN
) (
   input  logic                 clk,
   input  logic                 rst,
   lbm_step_sequencer_if.slave  bus
);

   localparam int              N          = GRID_W * GRID_H;
   localparam logic [ADDR_W:0] N_WB       = (ADDR_W + 1)'(N);
   localparam logic [7:0]      DRAIN_LOAD = 8'(DRAIN - 1);

   seq_state_t        state;
   logic              stream_valid_q;
   logic              coll_valid_q;
   logic [7:0]        drain_cnt;
   logic [ADDR_W:0]   wb_cnt;
   logic [31:0]       step_lat;
   logic [31:0]       steps_done_q;
   logic              bank_sel_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic              start_ok;
   logic              coll_acc;
   logic              wb_window;
   logic              wb_hit;
   logic [ADDR_W:0]   wb_total;
   logic              drain_end;
   logic              scan_adv;
   logic              scan_clear;
   logic              scan_last;
   logic [5:0]        scan_x;
   logic [5:0]        scan_y;
   logic [ADDR_W-1:0] scan_addr;

   assign start_ok   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
   assign coll_acc   = (state == ST_COLLIDE) && coll_valid_q && bus.coll_ready;
   assign wb_window  = (state == ST_COLLIDE) || (state == ST_C_WAIT);
   assign wb_hit     = wb_window && bus.coll_wb;
   assign wb_total   = wb_cnt + {{ADDR_W{1'b0}}, wb_hit};
   assign drain_end  = (state == ST_S_DRAIN) && bus.en && (drain_cnt == '0);
   assign scan_clear = start_ok || drain_end || (state == ST_SWAP);
   assign scan_adv   = ((state == ST_STREAM) && stream_valid_q && !scan_last) ||
                       (coll_acc && !scan_last);

   lattice_scan_counter #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .ADDR_W (ADDR_W)
   ) u_scan (
      .clk     (clk),
      .rst     (rst),
      .advance (scan_adv),
      .clear   (scan_clear),
      .x       (scan_x),
      .y       (scan_y),
      .addr    (scan_addr),
      .last    (scan_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         stream_valid_q <= 1'b0;
         coll_valid_q   <= 1'b0;
         drain_cnt      <= '0;
         wb_cnt         <= '0;
         step_lat       <= '0;
         steps_done_q   <= '0;
         bank_sel_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         if (bus.coll_wb && !wb_window) err_q <= 1'b1;
         if (wb_hit) wb_cnt <= wb_total;

         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  step_lat     <= bus.step;
                  steps_done_q <= '0;
                  err_q        <= 1'b0;
                  wb_cnt       <= '0;
                  if (bus.step == '0) begin
                     state  <= ST_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state          <= ST_STREAM;
                     stream_valid_q <= bus.en;
                     busy_q         <= 1'b1;
                     done_q         <= 1'b0;
                  end
               end
            end
            ST_STREAM: begin
               if (stream_valid_q && scan_last) begin
                  stream_valid_q <= 1'b0;
                  drain_cnt      <= DRAIN_LOAD;
                  state          <= ST_S_DRAIN;
               end else begin
                  stream_valid_q <= bus.en;
               end
            end
            ST_S_DRAIN: begin
               if (drain_end) begin
                  coll_valid_q <= 1'b1;
                  state        <= ST_COLLIDE;
               end else if (bus.en) begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            ST_COLLIDE: begin
               // a raised request is held until accepted, even with en low
               if (coll_acc) begin
                  if (scan_last) begin
                     coll_valid_q <= 1'b0;
                     state        <= ST_C_WAIT;
                  end else begin
                     coll_valid_q <= bus.en;
                  end
               end else if (!coll_valid_q) begin
                  coll_valid_q <= bus.en;
               end
            end
            ST_C_WAIT: begin
               if (bus.en && (wb_total == N_WB)) begin
                  bank_sel_q   <= ~bank_sel_q;
                  steps_done_q <= steps_done_q + 1'b1;
                  wb_cnt       <= '0;
                  state        <= ST_SWAP;
               end
            end
            ST_SWAP: begin
               if (steps_done_q == step_lat) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  state          <= ST_STREAM;
                  stream_valid_q <= bus.en;
               end
            end
            default: begin
               state          <= ST_IDLE;
               stream_valid_q <= 1'b0;
               coll_valid_q   <= 1'b0;
               busy_q         <= 1'b0;
               done_q         <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stream_valid = stream_valid_q;
   assign bus.coll_valid   = coll_valid_q;
   assign bus.node_addr    = scan_addr;
   assign bus.node_x       = scan_x;
   assign bus.node_y       = scan_y;
   assign bus.bank_sel     = bank_sel_q;
   assign bus.phase        = state;
   assign bus.steps_done   = steps_done_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;

endmodule
